// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
// The build macro ALU_ARB_STARVE_GUARD_EN is consumed by alu_arb_prio and alu_arbiter.
package alu_arb_pkg;

    localparam int unsigned OPCODE_W             = 3;
    localparam int unsigned OPERAND_W            = 8;
    localparam int unsigned RESULT_W             = 16;
    localparam int unsigned WAIT_MAX_DEFAULT     = 15;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned WAIT_CNT_W           = 8;
    localparam int unsigned STARVE_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_MAN = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage

// File: rtl/alu_arb_prio.sv
// Winner selection between the manual and CPU requesters, plus the registered owner.
// ALU_ARB_STARVE_GUARD_EN adds a starve counter that forces a grant to the losing side.
module alu_arb_prio
    import alu_arb_pkg::*;
`ifdef ALU_ARB_STARVE_GUARD_EN
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)
`endif
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   arb,
    input  logic   mode,
    input  logic   man_req,
    input  logic   cpu_req,
    output owner_t win,
    output owner_t owner
);

    logic both;

    assign both = man_req && cpu_req;

`ifdef ALU_ARB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    starve_hit;

    assign starve_hit = (starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT));

    // Counts consecutive contested wins by the priority side; any other outcome clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arb) begin
            if (both && !starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`endif

    always_comb begin
        win = cpu_req ? OWN_CPU : OWN_MAN;
        if (both) begin
            win = mode ? OWN_CPU : OWN_MAN;
`ifdef ALU_ARB_STARVE_GUARD_EN
            if (starve_hit) begin
                win = mode ? OWN_MAN : OWN_CPU;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner <= OWN_MAN;
        end else if (arb) begin
            owner <= win;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between a manual and a CPU requester: arbitrate, issue, wait with timeout, respond.
// Optional ALU_ARB_STARVE_GUARD_EN enables starvation protection for the lower-priority side.
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate and latch payload when any request is present
// ST_ISSUE | owner's grant and alu_start high for this one cycle
// ST_WAIT  | ALU bus held; wait for alu_ready or WAIT_MAX cycles
// ST_RESP  | owner's done pulse; result/result_err just updated
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WAIT_MAX     = WAIT_MAX_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 man_req,
    input  logic [OPCODE_W-1:0]  man_opcode,
    input  logic [OPERAND_W-1:0] man_operand,
    output logic                 man_gnt,
    output logic                 man_done,
    input  logic                 cpu_req,
    input  logic [OPCODE_W-1:0]  cpu_opcode,
    input  logic [OPERAND_W-1:0] cpu_operand,
    output logic                 cpu_gnt,
    output logic                 cpu_done,
    output logic [OPCODE_W-1:0]  alu_opcode,
    output logic [OPERAND_W-1:0] alu_operand,
    output logic                 alu_start,
    input  logic [RESULT_W-1:0]  alu_result,
    input  logic                 alu_ready,
    output logic [RESULT_W-1:0]  result,
    output logic                 result_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);

    generate
        if (WAIT_MAX == 0 || WAIT_MAX > 255) begin : g_bad_wait_max
            $error("alu_arbiter: WAIT_MAX must be in 1..255");
        end
        if (STARVE_LIMIT == 0) begin : g_bad_starve_limit
            $error("alu_arbiter: STARVE_LIMIT must be at least 1");
        end
    endgenerate

    state_t                 state;
    state_t                 state_nxt;
    owner_t                 win;
    owner_t                 owner;
    owner_t                 owner_nxt;
    logic                   arb;
    logic                   bus_on;
    logic [OPCODE_W-1:0]    op_q;
    logic [OPCODE_W-1:0]    op_nxt;
    logic [OPERAND_W-1:0]   opnd_q;
    logic [OPERAND_W-1:0]   opnd_nxt;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic [WAIT_CNT_W-1:0]  wait_cnt_nxt;
    logic [RESULT_W-1:0]    result_nxt;
    logic                   result_err_nxt;

    // Requests are only looked at in IDLE, so mode and payload changes mid-transaction are invisible.
    assign arb       = (state == ST_IDLE) && (man_req || cpu_req);
    assign owner_nxt = arb ? win : owner;
    assign bus_on    = (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT);

    alu_arb_prio
`ifdef ALU_ARB_STARVE_GUARD_EN
    #(
        .STARVE_LIMIT (STARVE_LIMIT)
    )
`endif
    u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb     (arb),
        .mode    (mode),
        .man_req (man_req),
        .cpu_req (cpu_req),
        .win     (win),
        .owner   (owner)
    );

    always_comb begin
        state_nxt      = state;
        op_nxt         = op_q;
        opnd_nxt       = opnd_q;
        wait_cnt_nxt   = wait_cnt;
        result_nxt     = result;
        result_err_nxt = result_err;
        unique case (state)
            ST_IDLE: begin
                if (arb) begin
                    state_nxt = ST_ISSUE;
                    if (win == OWN_CPU) begin
                        op_nxt   = cpu_opcode;
                        opnd_nxt = cpu_operand;
                    end else begin
                        op_nxt   = man_opcode;
                        opnd_nxt = man_operand;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = '0;
            end
            ST_WAIT: begin
                // A ready arriving on the last allowed cycle still counts as a good result.
                if (alu_ready) begin
                    result_nxt     = alu_result;
                    result_err_nxt = 1'b0;
                    state_nxt      = ST_RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    result_nxt     = '0;
                    result_err_nxt = 1'b1;
                    state_nxt      = ST_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            opnd_q      <= '0;
            wait_cnt    <= '0;
            result      <= '0;
            result_err  <= 1'b0;
            man_gnt     <= 1'b0;
            cpu_gnt     <= 1'b0;
            man_done    <= 1'b0;
            cpu_done    <= 1'b0;
            alu_start   <= 1'b0;
            alu_opcode  <= '0;
            alu_operand <= '0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            opnd_q      <= opnd_nxt;
            wait_cnt    <= wait_cnt_nxt;
            result      <= result_nxt;
            result_err  <= result_err_nxt;
            man_gnt     <= (state_nxt == ST_ISSUE) && (owner_nxt == OWN_MAN);
            cpu_gnt     <= (state_nxt == ST_ISSUE) && (owner_nxt == OWN_CPU);
            man_done    <= (state_nxt == ST_RESP) && (owner_nxt == OWN_MAN);
            cpu_done    <= (state_nxt == ST_RESP) && (owner_nxt == OWN_CPU);
            alu_start   <= (state_nxt == ST_ISSUE);
            alu_opcode  <= bus_on ? op_nxt : '0;
            alu_operand <= bus_on ? opnd_nxt : '0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-timing model queues expected grants and
// completions; an independent monitor pops and compares whenever the DUT shows one.
module tb_alu_arbiter;

    localparam int WAIT_MAX     = 15;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        man_req = 1'b0;
    logic [2:0]  man_opcode = '0;
    logic [7:0]  man_operand = '0;
    logic        cpu_req = 1'b0;
    logic [2:0]  cpu_opcode = '0;
    logic [7:0]  cpu_operand = '0;
    logic [15:0] alu_result = '0;
    logic        alu_ready = 1'b0;
    logic        man_gnt, man_done, cpu_gnt, cpu_done, alu_start, result_err;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_operand;
    logic [15:0] result;

    alu_arbiter #(
        .WAIT_MAX     (WAIT_MAX),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .man_req     (man_req),
        .man_opcode  (man_opcode),
        .man_operand (man_operand),
        .man_gnt     (man_gnt),
        .man_done    (man_done),
        .cpu_req     (cpu_req),
        .cpu_opcode  (cpu_opcode),
        .cpu_operand (cpu_operand),
        .cpu_gnt     (cpu_gnt),
        .cpu_done    (cpu_done),
        .alu_opcode  (alu_opcode),
        .alu_operand (alu_operand),
        .alu_start   (alu_start),
        .alu_result  (alu_result),
        .alu_ready   (alu_ready),
        .result      (result),
        .result_err  (result_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         edge_no;
        bit         cpu;
        logic [2:0] op;
        logic [7:0] opnd;
        int         end_edge;
    } gnt_exp_t;

    typedef struct {
        int          edge_no;
        bit          cpu;
        logic [15:0] res;
        bit          err;
    } done_exp_t;

    gnt_exp_t  gq[$];
    done_exp_t dq[$];
    int checks = 0;
    int errors = 0;

    // Model bookkeeping: next edge at which arbitration can happen and the WAIT window.
    int          free_edge = 0;
    int          ready_edge = -1;
    int          wait_lo = -1;
    int          wait_hi = -2;
    logic [15:0] ready_val = '0;
`ifdef ALU_ARB_STARVE_GUARD_EN
    int          starve = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // One input cycle, driven at the falling edge for the upcoming rising edge c.
    // lat = WAIT sample index at which the ALU answers; negative or >= WAIT_MAX means never.
    task automatic cycle(input bit rst, input bit mr, input bit cr, input bit md,
                         input logic [2:0] mop, input logic [7:0] mopd,
                         input logic [2:0] cop, input logic [7:0] copd,
                         input int lat, input logic [15:0] res);
        int        c;
        int        e;
        bit        win_cpu;
        gnt_exp_t  g;
        done_exp_t d;
        @(negedge clk);
        c           = edge_cnt;
        rst_n       = !rst;
        mode        = md;
        man_req     = mr;
        cpu_req     = cr;
        man_opcode  = mop;
        man_operand = mopd;
        cpu_opcode  = cop;
        cpu_operand = copd;
        if (rst) begin
            gq.delete();
            dq.delete();
            free_edge  = c + 1;
            ready_edge = -1;
            wait_lo    = -1;
            wait_hi    = -2;
`ifdef ALU_ARB_STARVE_GUARD_EN
            starve     = 0;
`endif
        end else if (c >= free_edge && (mr || cr)) begin
            if (mr && cr) begin
                win_cpu = md;
`ifdef ALU_ARB_STARVE_GUARD_EN
                if (starve >= STARVE_LIMIT) begin
                    win_cpu = !md;
                    starve  = 0;
                end else begin
                    starve++;
                end
`endif
            end else begin
                win_cpu = cr;
`ifdef ALU_ARB_STARVE_GUARD_EN
                starve  = 0;
`endif
            end
            if (lat < 0 || lat >= WAIT_MAX) begin
                e          = c + 1 + WAIT_MAX;
                d.res      = '0;
                d.err      = 1'b1;
                ready_edge = -1;
            end else begin
                e          = c + 2 + lat;
                d.res      = res;
                d.err      = 1'b0;
                ready_edge = e;
                ready_val  = res;
            end
            g.edge_no  = c;
            g.cpu      = win_cpu;
            g.op       = win_cpu ? cop : mop;
            g.opnd     = win_cpu ? copd : mopd;
            g.end_edge = e;
            gq.push_back(g);
            d.edge_no  = e;
            d.cpu      = win_cpu;
            dq.push_back(d);
            wait_lo    = c + 2;
            wait_hi    = e;
            free_edge  = e + 2;
        end
        if (!rst && c == ready_edge) begin
            alu_ready  = 1'b1;
            alu_result = ready_val;
        end else if (c >= wait_lo && c <= wait_hi) begin
            alu_ready  = 1'b0;
            alu_result = 16'($urandom);
        end else begin
            // Stray ready strobes outside WAIT must be ignored.
            alu_ready  = ($urandom_range(0, 3) == 0);
            alu_result = 16'($urandom);
        end
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, md, '0, '0, '0, '0, 0, '0);
    endtask

    initial begin : monitor
        int          idx;
        bit          rs;
        int          bus_from;
        int          bus_to;
        logic [2:0]  bop;
        logic [7:0]  bopd;
        logic [15:0] held;
        bit          held_err;
        gnt_exp_t    g;
        done_exp_t   d;
        bus_from = -1;
        bus_to   = -2;
        bop      = '0;
        bopd     = '0;
        held     = '0;
        held_err = 1'b0;
        forever begin
            @(posedge clk);
            idx = edge_cnt;
            rs  = rst_n;
            #1;
            if (!rs) begin
                chk("reset_outputs", {man_gnt, man_done, cpu_gnt, cpu_done, alu_start, result_err,
                                      alu_opcode, alu_operand, result}, '0);
                held     = '0;
                held_err = 1'b0;
                bus_to   = -2;
                continue;
            end
            if (man_gnt || cpu_gnt || alu_start) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {man_gnt, cpu_gnt, alu_start}, '0);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_edge", idx, g.edge_no);
                    chk("gnt_owner", {man_gnt, cpu_gnt, alu_start}, {!g.cpu, g.cpu, 1'b1});
                    bus_from = idx;
                    bus_to   = g.end_edge - 1;
                    bop      = g.op;
                    bopd     = g.opnd;
                end
            end else if (gq.size() > 0 && gq[0].edge_no < idx) begin
                chk("missing_gnt", idx, gq[0].edge_no);
                void'(gq.pop_front());
            end
            chk("alu_bus", {alu_opcode, alu_operand},
                (idx >= bus_from && idx <= bus_to) ? {bop, bopd} : 11'd0);
            if (man_done || cpu_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", {man_done, cpu_done}, '0);
                end else begin
                    d = dq.pop_front();
                    chk("done_edge", idx, d.edge_no);
                    chk("done_owner", {man_done, cpu_done}, {!d.cpu, d.cpu});
                    held     = d.res;
                    held_err = d.err;
                end
            end else if (dq.size() > 0 && dq[0].edge_no < idx) begin
                chk("missing_done", idx, dq[0].edge_no);
                void'(dq.pop_front());
            end
            chk("result", {result_err, result}, {held_err, held});
        end
    end

    initial begin : stimulus
        int lat;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 0, '0);

        // Manual-only transaction, ALU answers one cycle after start.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h5A, 3'd7, 8'hC3, 0, 16'h1234);
        idle(6, 1'b0);

        // Timeout, then ready on the very last WAIT cycle.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h11, 3'd0, 8'h00, -1, 16'hFFFF);
        idle(WAIT_MAX + 4, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd6, 8'h66, WAIT_MAX - 1, 16'hBEEF);
        idle(WAIT_MAX + 4, 1'b0);

        // Both request with CPU priority; manual keeps asking and follows after one IDLE cycle.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h33, 3'd4, 8'h44, 0, 16'h0A0A);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h55, 3'(i), 8'(i), 0, 16'h5050);
        idle(4, 1'b1);

        // Reset in WAIT with mode toggling; the next request is granted on the first edge out of reset.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h22, 3'd0, 8'h00, -1, 16'h0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0, 0, '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 3'd7, 8'h77, 1, 16'h7777);
        idle(6, 1'b0);

        // Continuous contention with manual priority.
        for (int i = 0; i < 60; i++)
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'($urandom), 8'($urandom), 3'($urandom), 8'($urandom),
                  0, 16'($urandom));
        idle(4, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_MAX + 4))
                                              : int'($urandom_range(0, 2));
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  1'($urandom), 3'($urandom), 8'($urandom), 3'($urandom), 8'($urandom),
                  lat, 16'($urandom));
        end

        idle(WAIT_MAX + 10, 1'b0);
        chk("gnt_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
